adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one 8-bit add datapath (sum plus carry-out) among N_REQ requesters.
- Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants at most one request per cycle.
- The registered result is returned on a single response channel, tagged with the requester ID and subject to backpressure.
- Sits between the client blocks and the shared adder, so the adder is never duplicated per client.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i presents an operand pair.
- req_ready  output  N_REQ  bit i: requester i is accepted this cycle (one-hot or zero).
- req_a  input  8*N_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*N_REQ  operand B; same packing as req_a.
- req_cin  input  N_REQ  carry-in, one bit per requester.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that produced the result.
- rsp_sum  output  8  a + b + cin, modulo 256.
- rsp_cout  output  1  carry-out of the 9-bit sum.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has top priority first.
  - Reset mid-transaction discards any held response; no partial state survives.
- FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | (rsp_ready & state==FULL). Since rsp_ready is combinational, req_ready depends on it.
- Arbitration:
  - Search starts at requester (last_grant+1) mod N_REQ and wraps around. The first i with req_valid[i]=1 wins.
  - req_ready[i] = can_accept & winner==i. All other bits are 0.
  - If can_accept=0, req_ready is all zero and last_grant is unchanged.
- On acceptance (handshake req_valid[i] & req_ready[i]):
  - {rsp_cout, rsp_sum} <= a_i + b_i + cin_i, computed as a 9-bit unsigned sum.
  - rsp_id <= i.
  - last_grant <= i.
  - Next state is FULL.
- Latency: a request accepted at edge t shows rsp_valid=1 from edge t onward, i.e. visible in cycle t+1.
- Throughput: 1 result per cycle while rsp_ready is held high (drain and accept in the same cycle).
- FULL and rsp_ready=0: rsp_* outputs held stable, no grants issued.
- FULL, rsp_ready=1, no valid request: next state is EMPTY. rsp_sum, rsp_id and rsp_cout keep their values, but are don't-care.
- Requester side: a requester must hold valid and its operands stable until its ready bit is seen. The arbiter does not latch operands before grant.
- Fairness: a requester held continuously valid is granted within N_REQ consecutive grants.
- Only one requester valid: it is granted every cycle can_accept=1, irrespective of the pointer.
- Arithmetic edge cases:
  - 0xFF + 0x00 + 1 gives sum 0x00, cout 1.
  - 0xFF + 0xFF + 1 gives sum 0xFF, cout 1.
  - Carry does not propagate between requests; each add uses only its own cin.

Test Plan:
- Reset, then requester 0 sends a=0x3C, b=0x4A, cin=0 with rsp_ready=1 -> req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x86, rsp_cout=0.
- All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1,...; one response per cycle, each tagged with the matching rsp_id.
- Requester 2 sends 0xFF+0xFF+1 while rsp_ready=0 for 3 cycles -> rsp_sum=0xFF, rsp_cout=1, rsp_id=2 held stable for all 3 cycles; req_ready=0000 throughout; on the cycle rsp_ready=1, the next request is granted in that same cycle.
- Requester 1 sends 0xFF+0x00+1 -> rsp_sum=0x00, rsp_cout=1; requester 3 sends 0x80+0x80+0 -> rsp_sum=0x00, rsp_cout=1.
- Requesters 1 and 3 valid, last_grant=1 -> requester 3 granted, then 1, then 3 (alternating).
- rst asserted while FULL with rsp_ready=0 -> next cycle rsp_valid=0, all rsp_* outputs 0, and requester 0 wins the next contention against 1, 2 and 3.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one 8-bit adder among N_REQ requesters
//
// Purpose:
//   Several client blocks share one 8-bit adder. Each client offers an operand
//   pair on a valid/ready handshake. A round-robin arbiter accepts at most one
//   request per cycle. The 9-bit result goes into a single response register,
//   tagged with the ID of the requester that produced it.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous, active-high reset
//   req_valid  - [N_REQ]   requester i presents an operand pair
//   req_ready  - [N_REQ]   requester i is accepted this cycle (one-hot or zero)
//   req_a      - [8*N_REQ] operand A, requester i on bits [8i+7:8i]
//   req_b      - [8*N_REQ] operand B, same packing as req_a
//   req_cin    - [N_REQ]   carry-in per requester
//   rsp_valid  - response register holds a result
//   rsp_ready  - consumer accepts the response
//   rsp_id     - [ID_W] requester that produced the result
//   rsp_sum    - [8]    a + b + cin modulo 256
//   rsp_cout   - carry-out of the 9-bit sum

module adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_sum,
    output logic                 rsp_cout
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;

    logic            can_accept;
    logic            found;
    logic [ID_W-1:0] winner;
    logic [7:0]      a_sel, b_sel;
    logic            cin_sel;
    logic [8:0]      sum9;
    logic            accept;
    logic [N_REQ-1:0] req_ready_c;

    // The response slot can take a new result when it is empty, or when the
    // current result leaves in this same cycle.
    assign can_accept = (state_q == EMPTY) | (rsp_ready & (state_q == FULL));

    // Round-robin search: scan from last_grant+1 upward with wrap-around and
    // keep the first valid requester found. Stepping k from 1 to N_REQ puts
    // last_grant itself at the lowest priority.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                a_sel   = req_a[8*i +: 8];
                b_sel   = req_b[8*i +: 8];
                cin_sel = req_cin[i];
            end
        end
    end

    assign sum9   = {1'b0, a_sel} + {1'b0, b_sel} + {8'b0, cin_sel};
    assign accept = can_accept & found;

    always_comb begin
        req_ready_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_c[i] = accept & (winner == ID_W'(i));
        end
    end

    assign req_ready = req_ready_c;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        if (accept) begin
            state_d      = FULL;
            last_grant_d = winner;
            rsp_id_d     = winner;
            rsp_sum_d    = sum9[7:0];
            rsp_cout_d   = sum9[8];
        end else if ((state_q == FULL) && rsp_ready) begin
            // Result leaves with nothing to replace it. Data fields keep their
            // old values; they are ignored while rsp_valid is low.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= ID_W'(N_REQ - 1);
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed self-checking bench for adder_rr_arbiter

module tb_adder_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_cin;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [7:0]         rsp_sum;
    logic               rsp_cout;

    int n_checks;
    int n_fail;

    adder_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
        req_valid[i]     = 1'b1;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_cin[i]       = cin;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [7:0] sum, input logic cout);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".sum"},   32'(rsp_sum),   32'(sum));
        check({tag, ".cout"},  32'(rsp_cout),  32'(cout));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Operand table for the all-requesters rotation, results worked by hand:
    //   0: 01+02+0 = 003 ; 1: 12+34+1 = 047 ; 2: 23+DD+0 = 100 ; 3: F0+10+1 = 101
    logic [7:0] rot_a    [4] = '{8'h01, 8'h12, 8'h23, 8'hF0};
    logic [7:0] rot_b    [4] = '{8'h02, 8'h34, 8'hDD, 8'h10};
    logic       rot_cin  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] rot_sum  [4] = '{8'h03, 8'h47, 8'h00, 8'h01};
    logic       rot_cout [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.id",    32'(rsp_id),    32'd0);
        check("rst.sum",   32'(rsp_sum),   32'd0);
        check("rst.cout",  32'(rsp_cout),  32'd0);
        check("rst.ready", 32'(req_ready), 32'd0);

        // Single request 3C+4A -> 86
        rsp_ready = 1'b1;
        set_req(0, 8'h3C, 8'h4A, 1'b0);
        #1;
        check("first.ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        check_rsp("first", 2'd0, 8'h86, 1'b0);
        step();
        check("drain.valid", 32'(rsp_valid), 32'd0);

        // All four valid: rotation 0,1,2,3,0,1,2,3 from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, rot_a[i], rot_b[i], rot_cin[i]);
        for (int n = 0; n < 8; n++) begin
            #1;
            check($sformatf("rot%0d.ready", n), 32'(req_ready), 32'(1 << (n % 4)));
            step();
            check_rsp($sformatf("rot%0d", n), 2'(n % 4), rot_sum[n % 4], rot_cout[n % 4]);
        end
        req_valid = '0;

        // Requester 2: FF+FF+1 then held under backpressure; last_grant is 3
        set_req(2, 8'hFF, 8'hFF, 1'b1);
        #1;
        check("bp.grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(0, 8'h05, 8'h06, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1;
            check($sformatf("bp%0d.ready", n), 32'(req_ready), 32'd0);
            check_rsp($sformatf("bp%0d", n), 2'd2, 8'hFF, 1'b1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        check_rsp("bp.next", 2'd0, 8'h0B, 1'b0);

        // Carry edge cases, each with its own cin
        set_req(1, 8'hFF, 8'h00, 1'b1);
        #1;
        check("edge1.ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check_rsp("edge1", 2'd1, 8'h00, 1'b1);
        set_req(3, 8'h80, 8'h80, 1'b0);
        #1;
        check("edge3.ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        check_rsp("edge3", 2'd3, 8'h00, 1'b1);

        // Lone requester 1 wins regardless of pointer, leaving last_grant=1
        set_req(1, 8'h10, 8'h20, 1'b0);
        #1;
        check("lone1.ready", 32'(req_ready), 32'b0010);
        step();
        check_rsp("lone1", 2'd1, 8'h30, 1'b0);

        // 1 and 3 contending from last_grant=1: 3,1,3
        set_req(3, 8'h01, 8'h01, 1'b1);
        #1;
        check("alt0.ready", 32'(req_ready), 32'b1000);
        step();
        check_rsp("alt0", 2'd3, 8'h03, 1'b0);
        check("alt1.ready", 32'(req_ready), 32'b0010);
        step();
        check_rsp("alt1", 2'd1, 8'h30, 1'b0);
        check("alt2.ready", 32'(req_ready), 32'b1000);
        step();
        check_rsp("alt2", 2'd3, 8'h03, 1'b0);
        req_valid = '0;

        // Reset while FULL and stalled: response discarded, pointer back to 3
        rsp_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check("mrst.valid", 32'(rsp_valid), 32'd0);
        check("mrst.id",    32'(rsp_id),    32'd0);
        check("mrst.sum",   32'(rsp_sum),   32'd0);
        check("mrst.cout",  32'(rsp_cout),  32'd0);
        for (int i = 0; i < 4; i++) set_req(i, rot_a[i], rot_b[i], rot_cin[i]);
        #1;
        check("mrst.ready", 32'(req_ready), 32'b0001);
        step();
        check_rsp("mrst.rsp", 2'd0, 8'h03, 1'b0);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
